// File: rtl/rx_video_timing.sv
// Receive-side video timing: pixel clock enable, raster counters and registered sync/DE/read-window decodes.
// Define RX_VTG_GENLOCK_EN to build the frame_sync genlock FSM; otherwise the raster free-runs from reset.
module rx_video_timing #(
  parameter int CLK_DIV   = 5,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int READ_LEAD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic       resync,
  output logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       mem_read,
  output logic       frame_active,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] RD_END  = 10'(H_ACTIVE - READ_LEAD);
  localparam logic [9:0] RD_BEG  = 10'(H_TOTAL - READ_LEAD);
  localparam logic [9:0] V_PRE   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VB_LAST = 10'(V_TOTAL - 2);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             running;
  logic [9:0]       h_next, v_next;

`ifdef RX_VTG_GENLOCK_EN
  localparam state_t     STATE_INIT = WAIT_SYNC;
  localparam logic [9:0] V_INIT     = V_ACT;
  localparam logic       FA_INIT    = 1'b0;

  // Two synchronizer stages, then a third flop for the toggle detect.
  logic [2:0] fs_pipe;
  logic       fs_toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fs_pipe <= '0;
    else     fs_pipe <= {fs_pipe[1:0], frame_sync};
  end

  assign fs_toggle = fs_pipe[2] ^ fs_pipe[1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (state == WAIT_SYNC) begin
      if (fs_toggle) state_next = RUN;
    end else if (resync) begin
      state_next = WAIT_SYNC;
    end
  end
`else
  localparam state_t     STATE_INIT = RUN;
  localparam logic [9:0] V_INIT     = 10'd0;
  localparam logic       FA_INIT    = 1'b1;

  logic unused_genlock_inputs;
  assign unused_genlock_inputs = frame_sync ^ resync;

  always_comb begin
    state_next = RUN;
  end
`endif

  assign tick    = (div_cnt == DIV_LAST);
  assign running = (state_next == RUN);

  // Leaving RUN reloads the sync-search position; entering RUN holds it until the next tick.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (!running) begin
      h_next = '0;
      v_next = V_INIT;
    end else if (state == RUN && tick) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  // Decodes are taken from the next counter values so they register in step with h_cnt/v_cnt.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      pix_ce       <= 1'b0;
      state        <= STATE_INIT;
      h_cnt        <= '0;
      v_cnt        <= V_INIT;
      de           <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      mem_read     <= 1'b0;
      frame_active <= FA_INIT;
      locked       <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
      pix_ce       <= (div_cnt == '0);
      state        <= state_next;
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      locked       <= running;
      de           <= running && (h_next < H_ACT) && (v_next < V_ACT);
      hsync        <= running && (h_next >= HS_BEG) && (h_next < HS_END);
      vsync        <= running && (v_next >= VS_BEG) && (v_next < VS_END);
      mem_read     <= running && (((h_next < RD_END) && (v_next < V_ACT)) ||
                                  ((h_next >= RD_BEG) && ((v_next == V_LAST) || (v_next < V_PRE))));
      frame_active <= running && !((v_next >= V_ACT) && (v_next <= VB_LAST));
    end
  end

endmodule

// File: tb/tb_rx_video_timing.sv
// Self-checking bench for rx_video_timing on a reduced raster, against a clock-count reference model.
// The model derives every output from the number of clk edges since reset and the genlock lock edge.
module tb_rx_video_timing;

  // Small raster keeps full frames within a short run; CLK_DIV and READ_LEAD keep their defaults.
  localparam int CD = 5;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int RL = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int MID_H = 20;
`ifdef RX_VTG_GENLOCK_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_sync = 1'b0;
  logic       resync = 1'b0;
  logic       pix_ce, hsync, vsync, de, mem_read, frame_active, locked;
  logic [9:0] h_cnt, v_cnt;

  int cyc;
  int lock_edge = -1;
  int errors = 0;
  int checks = 0;

  rx_video_timing #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .READ_LEAD(RL)
  ) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .resync(resync),
    .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync), .de(de), .mem_read(mem_read),
    .frame_active(frame_active), .h_cnt(h_cnt), .v_cnt(v_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected {h,v} and {pix_ce,de,hsync,vsync,mem_read,frame_active,locked} after n edges.
  function automatic void expect_at(input int n, output logic [19:0] ec, output logic [6:0] ef);
    int   pos, h, v;
    logic pc, d, hs, vs, mr, fa, lk;
    h  = 0;
    v  = GL ? VA : 0;
    pc = 1'b0; d = 1'b0; hs = 1'b0; vs = 1'b0; mr = 1'b0; lk = 1'b0;
    fa = (n == 0) && !GL;
    if (n > 0) begin
      pc = ((n - 1) % CD == 0);
      if (!GL || (lock_edge >= 0 && n >= lock_edge)) begin
        pos = GL ? (VA * HT + n / CD - lock_edge / CD) : n / CD;
        pos = pos % (HT * VT);
        h   = pos % HT;
        v   = pos / HT;
        lk  = 1'b1;
        d   = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        mr  = ((h < HA - RL) && (v < VA)) || ((h >= HT - RL) && ((v == VT - 1) || (v < VA - 1)));
        fa  = !((v >= VA) && (v <= VT - 2));
      end
    end
    ec = {10'(h), 10'(v)};
    ef = {pc, d, hs, vs, mr, fa, lk};
  endfunction

  task automatic check_now(input string tag);
    logic [19:0] ec, ac;
    logic [6:0]  ef, af;
    expect_at(cyc, ec, ef);
    ac = {h_cnt, v_cnt};
    af = {pix_ce, de, hsync, vsync, mem_read, frame_active, locked};
    checks++;
    assert (ac === ec) else begin
      errors++;
      $error("FAIL %s counters cyc=%0d observed h=%0d v=%0d expected h=%0d v=%0d",
             tag, cyc, ac[19:10], ac[9:0], ec[19:10], ec[9:0]);
    end
    checks++;
    assert (af === ef) else begin
      errors++;
      $error("FAIL %s flags(pce,de,hs,vs,mr,fa,lk) cyc=%0d observed %b expected %b", tag, cyc, af, ef);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic run_cycles(input int n, input bit rand_fs, input bit rand_rs, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_now(tag);
      if (rand_fs) frame_sync = 1'($urandom_range(0, 1));
      if (rand_rs) resync = ($urandom_range(0, 7) == 0);
    end
    resync = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("pix_ce_first_clk", int'(pix_ce), 1);
    repeat (3) @(posedge clk);
    #1 check_val("h_before_5clk", int'(h_cnt), 0);
    @(posedge clk); #1;
    check_val("h_after_5clk", int'(h_cnt), GL ? 0 : 1);
  endtask

  // One frame period of clocks: any such window holds exactly one frame's worth of de.
  task automatic frame_window(input string tag);
    int de_clks = 0;
    int ovl = 0;
    repeat (HT * VT * CD) begin
      @(negedge clk);
      check_now(tag);
      de_clks += int'(de);
      if (de && (hsync || vsync)) ovl++;
    end
    check_val({tag, "_de_clks"}, de_clks, HA * VA * CD);
    check_val({tag, "_sync_overlap"}, ovl, 0);
  endtask

  task automatic mid_line_reset();
    logic [19:0] ec;
    logic [6:0]  ef;
    bit          found = 1'b0;
    for (int i = 0; i < 2 * HT * CD; i++) begin
      @(negedge clk);
      check_now("pre_reset");
      expect_at(cyc, ec, ef);
      if (int'(ec[19:10]) == MID_H) begin
        found = 1'b1;
        break;
      end
    end
    check_val("mid_reset_target", int'(found), 1);
    #2;
    rst = 1'b1;
    lock_edge = -1;
    frame_sync = 1'b0;
    resync = 1'b0;
    #1 check_now("async_reset");
    repeat (2) begin
      @(negedge clk);
      check_now("held_reset");
    end
    release_reset();
  endtask

`ifdef RX_VTG_GENLOCK_EN
  task automatic lock_and_first_de();
    bit found = 1'b0;
    int first = -1;
    @(negedge clk);
    check_now("pre_toggle");
    frame_sync = ~frame_sync;
    lock_edge = cyc + 3;
    repeat (2) @(posedge clk);
    #1 check_val("locked_before_latency", int'(locked), 0);
    @(posedge clk);
    #1 check_val("lock_latency", int'(locked), 1);
    for (int i = 0; i < (VT * HT + 2) * CD; i++) begin
      @(negedge clk);
      check_now("lead_in");
      if (de) begin
        found = 1'b1;
        first = cyc;
        break;
      end
    end
    check_val("first_de_seen", int'(found), 1);
    check_val("first_de_edge", first, CD * (lock_edge / CD + (VT - VA) * HT));
  endtask

  task automatic resync_mid_frame();
    logic [19:0] ec;
    logic [6:0]  ef;
    bit          found = 1'b0;
    run_cycles($urandom_range(50, 400), 1'b1, 1'b0, "run_toggles");
    run_cycles(5, 1'b0, 1'b0, "quiet");
    for (int i = 0; i < HT * VT * CD; i++) begin
      @(negedge clk);
      check_now("seek_de");
      expect_at(cyc, ec, ef);
      if (ef[5]) begin
        found = 1'b1;
        break;
      end
    end
    check_val("resync_target_found", int'(found), 1);
    resync = 1'b1;
    @(posedge clk);
    #1 resync = 1'b0;
    lock_edge = -1;
    check_val("resync_de_drop", int'(de), 0);
    check_val("resync_v_reload", int'(v_cnt), VA);
    check_val("resync_unlocked", int'(locked), 0);
    run_cycles(200, 1'b0, 1'b0, "resync_wait");
  endtask

  task automatic toggle_with_resync();
    @(negedge clk);
    check_now("pre_toggle2");
    frame_sync = ~frame_sync;
    lock_edge = cyc + 3;
    repeat (2) begin
      @(negedge clk);
      check_now("toggle_pending");
    end
    resync = 1'b1;
    @(posedge clk);
    #1 resync = 1'b0;
    check_val("toggle_beats_resync", int'(locked), 1);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    check_now("reset");
    release_reset();
`ifdef RX_VTG_GENLOCK_EN
    run_cycles(2000, 1'b0, 1'b0, "hold");
    check_val("hold_locked", int'(locked), 0);
    lock_and_first_de();
    resync_mid_frame();
    toggle_with_resync();
    frame_window("genlock_frame");
    mid_line_reset();
    run_cycles(300, 1'b0, 1'b0, "post_reset_wait");
`else
    run_cycles(3000, 1'b1, 1'b1, "free_run");
    frame_window("free_frame");
    mid_line_reset();
    run_cycles(1000, 1'b1, 1'b1, "post_reset_run");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
